// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive path:
//   - rx_state_t : Gray-coded receiver FSM states
//   - MIN_PRESCALE : lowest accepted clocks-per-bit (smaller values are clamped)
//   - EVEN / ODD : PAR_TYP encodings
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } rx_state_t;

    localparam int unsigned MIN_PRESCALE = 8;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Bit-timing edge counter and RX_IN sampling for uart_rx_ctrl.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   : RX_IN captured at edges mid-1, mid, mid+1 and voted 2-of-3
//   undefined : single capture at edge mid
// In both builds the result is presented at edge mid+2.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            advance the edge counter this cycle
//   i_clr           force the edge counter back to 0 (takes priority)
//   i_prescale      latched, clamped clocks per bit
//   i_rx            synchronised serial line
//   o_edge_last     edge counter == prescale-1
//   o_bit_rdy       edge counter == mid+2
//   o_voted_bit     sampled bit value, valid with o_bit_rdy
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_rx,
    output logic                  o_edge_last,
    output logic                  o_bit_rdy,
    output logic                  o_voted_bit
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [PRESCALE_W-1:0] w_mid;

    assign w_mid       = i_prescale >> 1;
    assign o_edge_last = (r_edge_cnt == i_prescale - ONE);
    assign o_bit_rdy   = (r_edge_cnt == w_mid + TWO);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_cnt <= '0;
        end else if (i_clr) begin
            r_edge_cnt <= '0;
        end else if (i_en) begin
            if (o_edge_last) r_edge_cnt <= '0;
            else             r_edge_cnt <= r_edge_cnt + ONE;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_s_lo, r_s_mid, r_s_hi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_lo  <= 1'b0;
            r_s_mid <= 1'b0;
            r_s_hi  <= 1'b0;
        end else begin
            if (r_edge_cnt == w_mid - ONE) r_s_lo  <= i_rx;
            if (r_edge_cnt == w_mid)       r_s_mid <= i_rx;
            if (r_edge_cnt == w_mid + ONE) r_s_hi  <= i_rx;
        end
    end

    assign o_voted_bit = (r_s_lo & r_s_mid) | (r_s_lo & r_s_hi) | (r_s_mid & r_s_hi);
`else
    logic r_s_mid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  r_s_mid <= 1'b0;
        else if (r_edge_cnt == w_mid)  r_s_mid <= i_rx;
    end

    assign o_voted_bit = r_s_mid;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// UART receive controller: start detection, data/parity/stop sequencing,
// error flagging and single-cycle data_valid. Bit timing and sampling live
// in uart_rx_sampler.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler).
// Ports:
//   CLK, RST     oversampling clock, asynchronous active-low reset
//   RX_IN        synchronised serial line, idle high
//   PAR_EN       parity bit present;  PAR_TYP 0 = even, 1 = odd
//   STP_2        two stop bits
//   Prescale     clocks per bit (values below 8 treated as 8)
//   P_DATA       last good frame, LSB received first
//   data_valid   one-cycle pulse when P_DATA updates
//   par_err      one-cycle pulse at frame end on parity mismatch
//   stp_err      one-cycle pulse at frame end when a stop bit sampled 0
//   strt_glitch  one-cycle pulse when the start bit is rejected
//   busy         high outside IDLE
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP_2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH);

    rx_state_t             r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stp2;
    logic                  r_stop_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_flag;
    logic                  r_stp_flag;

    logic                  w_detect;
    logic                  w_edge_last;
    logic                  w_bit_rdy;
    logic                  w_voted;
    logic                  w_last_stop;
    logic                  w_glitch;
    logic                  w_frame_end;
    logic [PRESCALE_W-1:0] w_presc_clamped;

    assign w_presc_clamped = (Prescale < PRESCALE_W'(MIN_PRESCALE)) ?
                             PRESCALE_W'(MIN_PRESCALE) : Prescale;

    assign w_detect    = (r_state == IDLE) && !RX_IN;
    assign w_last_stop = !r_stp2 || r_stop_cnt;
    assign w_glitch    = (r_state == START) && w_bit_rdy && w_voted;
    assign w_frame_end = (r_state == STOP) && w_bit_rdy && w_last_stop;

    // The edge counter is cleared on the deciding cycle of a glitch or frame
    // end so it already reads 0 if the very next cycle detects a start bit.
    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .i_en        ((r_state != IDLE) || w_detect),
        .i_clr       (w_glitch || w_frame_end),
        .i_prescale  (r_presc),
        .i_rx        (RX_IN),
        .o_edge_last (w_edge_last),
        .o_bit_rdy   (w_bit_rdy),
        .o_voted_bit (w_voted)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_presc     <= PRESCALE_W'(MIN_PRESCALE);
            r_par_en    <= 1'b0;
            r_par_typ   <= EVEN;
            r_stp2      <= 1'b0;
            r_stop_cnt  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_flag  <= 1'b0;
            r_stp_flag  <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_detect) begin
                        r_state    <= START;
                        busy       <= 1'b1;
                        r_presc    <= w_presc_clamped;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_stp2     <= STP_2;
                        r_stop_cnt <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_par_flag <= 1'b0;
                        r_stp_flag <= 1'b0;
                    end
                end
                START: begin
                    if (w_glitch) begin
                        strt_glitch <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_edge_last) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_rdy) r_shift <= {w_voted, r_shift[DATA_WIDTH-1:1]};
                    if (w_edge_last) begin
                        if (r_bit_cnt == BCW'(DATA_WIDTH - 1))
                            r_state <= r_par_en ? PARITY : STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_bit_rdy && (w_voted != ((^r_shift) ^ (r_par_typ == ODD))))
                        r_par_flag <= 1'b1;
                    if (w_edge_last) r_state <= STOP;
                end
                STOP: begin
                    if (w_frame_end) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        par_err <= r_par_flag;
                        stp_err <= r_stp_flag | !w_voted;
                        if (!r_par_flag && !r_stp_flag && w_voted) begin
                            P_DATA     <= r_shift;
                            data_valid <= 1'b1;
                        end
                    end else begin
                        if (w_bit_rdy && !w_voted) r_stp_flag <= 1'b1;
                        if (w_edge_last)           r_stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Scoreboard bench for uart_rx_ctrl (DATA_WIDTH 8, PRESCALE_W 6).
// Frames are built bit by bit from their field values; the expected outcome
// (byte, error pulses, pulse cycle) is queued when a frame starts and a
// monitor matches it against every pulse the DUT presents.
module tb_uart_rx_ctrl;

    logic       CLK, RST, RX_IN, PAR_EN, PAR_TYP, STP_2;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, strt_glitch, busy;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .STP_2(STP_2), .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch), .busy(busy)
    );

    typedef struct {
        bit         dv, pe, se, sg;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_good = 8'h00;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit dv, pe, se, sg, input logic [7:0] d, input int c);
        ev_t e;
        e.dv = dv; e.pe = pe; e.se = se; e.sg = sg; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            if (RST && (data_valid || par_err || stp_err || strt_glitch)) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse dv=%0b pe=%0b se=%0b sg=%0b at cycle %0d",
                             data_valid, par_err, stp_err, strt_glitch, cyc);
                end else begin
                    e = q.pop_front();
                    if ({data_valid, par_err, stp_err, strt_glitch} != {e.dv, e.pe, e.se, e.sg} ||
                        P_DATA !== e.data || cyc != e.cyc || busy !== 1'b0) begin
                        failures++;
                        $display("FAIL pulse got dv=%0b pe=%0b se=%0b sg=%0b data=%h cyc=%0d busy=%0b expected dv=%0b pe=%0b se=%0b sg=%0b data=%h cyc=%0d busy=0",
                                 data_valid, par_err, stp_err, strt_glitch, P_DATA, cyc, busy,
                                 e.dv, e.pe, e.se, e.sg, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                              input logic [5:0] p, input bit par_bad, input bit [1:0] stop_bad,
                              input logic [7:0] spike, input int abort_at);
        int peff, mid, nb, n, b, o, sb;
        logic [11:0] bits;
        logic [7:0]  drx;
        logic        pbit, v;
        bit          perr, serr;
        peff = (p < 6'd8) ? 8 : int'(p);
        mid  = peff / 2;
        nb   = 1 + 8 + int'(pe) + 1 + int'(s2);
        pbit = (^d) ^ pt ^ par_bad;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = pbit;
        drx = d;
`ifndef UART_RX_MAJORITY_VOTE_EN
        drx = d & ~spike;
`endif
        perr = pe && (pbit != ((^drx) ^ pt));
        serr = stop_bad[0] || (s2 && stop_bad[1]);
        n = cyc;
        if (abort_at < 0) begin
            if (perr || serr) begin
                push_ev(1'b0, perr, serr, 1'b0, last_good, n + (nb - 1) * peff + mid + 3);
            end else begin
                last_good = drx;
                push_ev(1'b1, 1'b0, 1'b0, 1'b0, drx, n + (nb - 1) * peff + mid + 3);
            end
        end
        PAR_EN = pe; PAR_TYP = pt; STP_2 = s2; Prescale = p;
        for (int j = 0; j < nb * peff; j++) begin
            b = j / peff;
            o = j % peff;
            v = bits[b];
            if (b >= 1 && b <= 8 && spike[b-1] && o == mid) v = 1'b0;
            sb = b - (9 + int'(pe));
            if (sb >= 0 && stop_bad[sb] && o <= mid + 1) v = 1'b0;
            RX_IN = v;
            if (j == abort_at) begin
                RST = 1'b0;
                #2;
                chk("reset_outputs", {18'd0, P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}, 32'd0);
                @(posedge CLK); #1;
                chk("reset_hold", {18'd0, P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}, 32'd0);
                RX_IN = 1'b1;
                RST = 1'b1;
                last_good = 8'h00;
                repeat (3) @(posedge CLK);
                #1;
                return;
            end
            if (j == 1) begin
                chk("busy_rise", {31'd0, busy}, 32'd1);
                // Config changes after detection must not affect this frame.
                PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STP_2 = 1'($urandom);
                Prescale = 6'($urandom);
            end
            @(posedge CLK); #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic send_glitch(input int g, input logic [5:0] p);
        int peff, mid, n;
        peff = (p < 6'd8) ? 8 : int'(p);
        mid  = peff / 2;
        n = cyc;
        Prescale = p;
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, last_good, n + mid + 3);
        for (int j = 0; j <= mid + 5; j++) begin
            RX_IN = (j < g) ? 1'b0 : 1'b1;
            if (j == 1)       chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
            if (j == mid + 3) chk("glitch_busy_low", {31'd0, busy}, 32'd0);
            @(posedge CLK); #1;
        end
    endtask

    task automatic idle(input int k);
        RX_IN = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int          pmid;
        logic [5:0]  p;
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STP_2 = 1'b0; Prescale = 6'd8;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", {18'd0, P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}, 32'd0);
        RST = 1'b1;
        idle(2);

        // 8N1 0xA5, then parity error on 0x3C, start glitch, second-stop error, spikes
        send_frame(8'hA5, 0, 0, 0, 6'd8, 0, 2'b00, 8'h00, -1);
        idle(3);
        send_frame(8'h3C, 1, 0, 0, 6'd8, 1, 2'b00, 8'h00, -1);
        idle(3);
        send_glitch(2, 6'd8);
        idle(2);
        send_frame(8'h6B, 0, 0, 1, 6'd8, 0, 2'b10, 8'h00, -1);
        idle(3);
        send_frame(8'hFF, 1, 1, 0, 6'd10, 0, 2'b00, 8'h5A, -1);
        idle(3);
        // clamped prescale
        send_frame(8'h0F, 1, 1, 1, 6'd3, 0, 2'b00, 8'h00, -1);
        idle(1);
        // back-to-back
        send_frame(8'h12, 0, 0, 0, 6'd8, 0, 2'b00, 8'h00, -1);
        send_frame(8'hEF, 0, 0, 0, 6'd8, 0, 2'b00, 8'h00, -1);
        idle(2);
        // reset inside DATA, then a clean frame
        send_frame(8'h77, 0, 0, 0, 6'd8, 0, 2'b00, 8'h00, 3 * 8 + 2);
        send_frame(8'h81, 0, 0, 0, 6'd8, 0, 2'b00, 8'h00, -1);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            p = 6'($urandom_range(4, 20));
            if ($urandom_range(0, 7) == 0) begin
                pmid = ((p < 6'd8) ? 8 : int'(p)) / 2;
                send_glitch($urandom_range(1, pmid), p);
            end else begin
                send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), p,
                           ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, -1);
            end
            idle($urandom_range(0, 2));
        end

        for (int k = 0; k < 300 && q.size() > 0; k++) @(posedge CLK);
        idle(20);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised UART receive controller for the UART_RX path. It integrates bit-timing counters, start/data/parity/stop sequencing, majority-vote sampling and error flagging in one block. It supports configurable data width, odd/even parity, one or two stop bits, and back-to-back frames. It sits between the RX_IN synchroniser and the RX data FIFO/sync stage and drives P_DATA with a single-cycle data_valid.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- PRESCALE_W, 6: width of Prescale and of the internal edge counter.
- CLK  in  1  oversampling clock.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line, already synchronised; idle high.
- PAR_EN  in  1  parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STP_2  in  1  two stop bits.
- Prescale  in  PRESCALE_W  clocks per bit; values below 8 are clamped to 8.
- P_DATA  out  DATA_WIDTH  last good frame, LSB received first.
- data_valid  out  1  one-cycle pulse when P_DATA updates.
- par_err  out  1  one-cycle pulse at frame end when parity mismatches.
- stp_err  out  1  one-cycle pulse at frame end when any stop bit samples 0.
- strt_glitch  out  1  one-cycle pulse when the start bit is rejected.
- busy  out  1  high in every state except IDLE.

## Operation
- States, Gray coded: IDLE 000, START 001, DATA 011, PARITY 010, STOP 110.
- In IDLE, RX_IN==0 is the start detection.
  - The detection cycle is edge 0 of the start bit.
  - PAR_EN, PAR_TYP, STP_2 and clamped Prescale are latched on this cycle.
  - Later changes to these inputs are ignored until the next IDLE.
- edge_cnt runs 0..Prescale-1 and wraps at the end of each bit; bit_cnt counts data bits.
- Let mid = Prescale>>1.
  - RX_IN is captured at edges mid-1, mid and mid+1.
  - The voted bit (2-of-3 majority) is evaluated at edge mid+2.
- START:
  - At mid+2, a voted bit of 1 pulses strt_glitch next cycle and moves to IDLE.
  - Otherwise the block moves to DATA at edge Prescale-1.
- DATA:
  - At mid+2, the voted bit shifts into the shift register at the MSB, so it is right-shifting.
  - At Prescale-1 with bit_cnt==DATA_WIDTH-1, the block moves to PARITY if PAR_EN, else to STOP.
- PARITY: at mid+2, a mismatch against (^shift) ^ PAR_TYP sets the internal parity flag.
- STOP:
  - At mid+2 of each stop bit, a voted bit of 0 sets the internal stop flag.
  - With STP_2, the first stop bit runs to Prescale-1 and the second is then checked.
- Frame end, at mid+2 of the final stop bit:
  - The block returns to IDLE on the next cycle; the remaining half stop bit is not waited for, so an immediately following start bit is caught.
  - par_err and stp_err pulse next cycle according to the flags.
  - With no error flag set, P_DATA loads the shift register and data_valid pulses on that same cycle.
  - With any error, P_DATA holds its previous value.
- Reset, at any time:
  - State goes to IDLE and all counters and flags clear.
  - P_DATA and all pulse outputs go to 0.
  - busy goes to 0.

## Timing
- All outputs are registered; no combinational path from RX_IN to any output.
- Cycle numbers below count from the detection cycle, which is cycle 0.
- A frame has N = 1 + DATA_WIDTH + PAR_EN + 1 + STP_2 bits.
- data_valid, par_err and stp_err pulse at cycle (N-1)*Prescale + mid + 3.
- strt_glitch pulses at cycle mid+3; busy is low from that same cycle.
- busy rises at cycle 1 and falls on the cycle of the frame-end pulse.
- The earliest next detection is the cycle after the frame-end pulse.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: 3-sample 2-of-3 vote as above.
- UART_RX_MAJORITY_VOTE_EN undefined: a single sample is taken at edge mid.
  - The sample is still evaluated at mid+2, so all timing is identical.
  - The edge mid-1 and mid+1 capture registers are removed.

## Structure
- Package uart_rx_pkg holds:
  - the state typedef and its encodings;
  - MIN_PRESCALE = 8;
  - the PAR_TYP encodings EVEN = 0 and ODD = 1.
- Sub-module uart_rx_sampler contains:
  - the edge counter;
  - the sample capture registers and majority vote;
  - outputs edge_last (edge==Prescale-1) and bit_rdy (edge==mid+2) with voted_bit.
- The FSM, shift register, bit counter and error flags stay in uart_rx_ctrl.

## Test plan
- 8N1, Prescale 8, byte 0xA5 -> data_valid at cycle 79, P_DATA=0xA5, no error pulses. Repeat with DATA_WIDTH=7 and byte 0x55 -> data_valid at cycle 71.
- PAR_EN=1, PAR_TYP=0, byte 0x3C sent with parity bit 1 -> par_err at cycle 87, no data_valid, P_DATA keeps 0xA5.
- RX_IN low for 2 cycles only, Prescale 8 -> strt_glitch at cycle 7, busy low at cycle 7, P_DATA unchanged.
- STP_2=1, second stop bit driven 0 -> stp_err at cycle 87, no data_valid. Also single-cycle low spikes at edge mid of data bits -> rejected when the macro is defined, corrupt data when undefined.
- Two 8N1 frames, 0x12 then 0xEF, with the second start bit beginning exactly at the end of the first stop bit -> two data_valid pulses 80 cycles apart, correct bytes.
- RST asserted in DATA mid-frame, then released and a frame 0x81 sent -> all outputs 0 during reset, data_valid with P_DATA=0x81.
